// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port memory between the CPU datapath and an external requester (loader/video).
// Latency: mem_en one cycle after grant; write ack 2 cycles, read ack 2+RD_LAT cycles after the granting cycle.
// Backpressure: requests are held until their ack; the loser of arbitration waits and receives no ack.
//
// Ports:
//   clock, reset (async, active-low)
//   cpu_req/we/addr/wdata -> cpu_ack/cpu_rdata     CPU request port
//   ext_req/we/addr/wdata -> ext_ack/ext_rdata     external request port
//   mem_en/we/addr/wdata, mem_rdata                memory macro side
//   busy (state != IDLE), owner (0 = CPU, 1 = ext; current or most recent grant)
//
// Build option: define MEM_ARB_RR_EN for strict round-robin arbitration.
// Without it the CPU has fixed priority, limited to MAX_BURST consecutive
// grants while ext_req is waiting.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] lat_cnt;
    logic       grant_ext;   // arbitration winner for this IDLE cycle
    logic       grant;       // a grant is made this cycle

    assign grant = (state == IDLE) && (cpu_req || ext_req);

`ifdef MEM_ARB_RR_EN
    // Set when the CPU was granted last, so ext wins the next tie.
    // Resets to 0 so the first tie after reset goes to the CPU.
    logic rr_ext_pri;

    assign grant_ext = ext_req && (!cpu_req || rr_ext_pri);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ext_pri <= 1'b0;
        end else if (grant) begin
            rr_ext_pri <= !grant_ext;
        end
    end
`else
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    // Counts CPU grants made while ext is waiting; saturates at BURST_MAX,
    // at which point a waiting ext request takes the next slot.
    logic [3:0] burst_cnt;

    assign grant_ext = ext_req && (!cpu_req || (burst_cnt == BURST_MAX));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_cnt <= 4'd0;
        end else if (grant) begin
            if (grant_ext) begin
                burst_cnt <= 4'd0;
            end else if (ext_req && (burst_cnt != BURST_MAX)) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end
`endif

    // State register, latched access and read-data capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lat_cnt   <= 3'd0;
            owner     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner     <= grant_ext;
                mem_we    <= grant_ext ? ext_we    : cpu_we;
                mem_addr  <= grant_ext ? ext_addr  : cpu_addr;
                mem_wdata <= grant_ext ? ext_wdata : cpu_wdata;
            end
            if ((state == ISSUE) && !mem_we) begin
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            // Count 1 is the cycle in which mem_rdata for this access is valid.
            if ((state == WAIT) && (lat_cnt == 3'd1)) begin
                if (owner) begin
                    ext_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    // Next state and state-decoded strobes; decoding from the state register
    // makes mem_en and the acks fall as soon as reset is asserted.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        cpu_ack   = 1'b0;
        ext_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || ext_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                state_nxt = mem_we ? ACK : WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                cpu_ack   = !owner;
                ext_ack   = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with RD_LAT=3, MAX_BURST=4.
// Ack timing/data expectations are queued when a request is driven and
// compared against the acks a monitor records from the DUT.
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int LAT  = 3;
    localparam int MAXB = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          ext_req = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          cpu_ack, ext_ack, mem_en, mem_we, busy, owner;
    logic [DW-1:0] cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_BURST(MAXB)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: 256 bytes by addr[7:0], reloaded while reset is low.
    // Read data appears LAT cycles after the mem_en cycle; other cycles carry EE.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rpipe [LAT];
    assign mem_rdata = rpipe[LAT-1];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h77] <= 8'h3C;
            mem[8'hFF] <= 8'hC3;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 8'hEE;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    // Ack monitor
    typedef struct { bit cpu; bit ext; logic [DW-1:0] crd; logic [DW-1:0] erd; logic busy; int cyc; } obs_t;
    obs_t obs_q[$];
    always @(negedge clock) begin
        if (cpu_ack || ext_ack) obs_q.push_back('{cpu_ack, ext_ack, cpu_rdata, ext_rdata, busy, cyc});
    end

    // Scoreboard
    typedef struct { bit port; bit rd; logic [DW-1:0] rdata; int cyc; } exp_t;
    exp_t exp_q[$];

    typedef struct { bit port; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata; } vec_t;
    vec_t vecs [9];

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_crd = '0;
    logic [DW-1:0] exp_erd = '0;
`ifdef MEM_ARB_RR_EN
    bit            last_port = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input bit port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (port) begin
            ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
    endtask

    task automatic expect_ack(input bit port, input bit we, input logic [DW-1:0] rd, input int c);
        exp_q.push_back('{port, !we, rd, c});
    endtask

    // Waits for n acks on one port (bounded), then drops that port's request.
    task automatic wait_acks(input bit port, input int n);
        int got = 0;
        for (int g = 0; g < 80 && got < n; g++) begin
            @(negedge clock);
            if (port ? ext_ack : cpu_ack) got++;
        end
        check(port ? "ext_ack_count" : "cpu_ack_count", got, n);
        if (port) ext_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic score();
        obs_t o;
        exp_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack: cpu_ack=%0b ext_ack=%0b at cycle %0d, no ack expected", o.cpu, o.ext, o.cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.rd) begin
                    if (e.port) exp_erd = e.rdata; else exp_crd = e.rdata;
                end
                check("ack_cpu", o.cpu, !e.port);
                check("ack_ext", o.ext, e.port);
                check("ack_cycle", o.cyc, e.cyc);
                check("cpu_rdata", o.crd, exp_crd);
                check("ext_rdata", o.erd, exp_erd);
                check("ack_busy", o.busy, 1);
            end
        end
        check("acks_outstanding", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);       check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);   check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_owner", owner, 0);
        check("rst_cpu_ack", cpu_ack, 0); check("rst_ext_ack", ext_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0); check("rst_ext_rdata", ext_rdata, 0);
    endtask

    // Single-port transaction starting in an IDLE cycle; returns in the next IDLE cycle.
    task automatic run_single(input vec_t v);
        int t0;
        drive(v.port, v.we, v.addr, v.wdata);
        t0 = cyc;
        expect_ack(v.port, v.we, v.rdata, t0 + (v.we ? 2 : 2 + LAT));
`ifdef MEM_ARB_RR_EN
        last_port = v.port;
`endif
        @(negedge clock);
        check("c1_mem_en", mem_en, 1);
        check("c1_mem_we", mem_we, v.we);
        check("c1_mem_addr", mem_addr, v.addr);
        if (v.we) check("c1_mem_wdata", mem_wdata, v.wdata);
        check("c1_owner", owner, v.port);
        check("c1_busy", busy, 1);
        wait_acks(v.port, 1);
        @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_mem_en", mem_en, 0);
        score();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit first;

        vecs[0] = '{1'b0, 1'b1, 16'h0123, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 16'h0456, 8'h5A, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 16'h0123, 8'h00, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 16'h0456, 8'h00, 8'h5A};
        vecs[4] = '{1'b0, 1'b0, 16'h0077, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 8'hC3};
        vecs[6] = '{1'b0, 1'b1, 16'h00FF, 8'h11, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 8'h11};
        vecs[8] = '{1'b0, 1'b0, 16'h0456, 8'h00, 8'h5A};

        repeat (2) @(negedge clock);
        check_reset_outputs();
        reset = 1'b1;
        @(negedge clock);

`ifdef MEM_ARB_RR_EN
        // Both ports requesting continuously: strict alternation starting with CPU.
        drive(0, 1'b1, 16'h0010, 8'h01);
        drive(1, 1'b1, 16'h0020, 8'h02);
        t0 = cyc;
        expect_ack(0, 1'b1, 8'h00, t0 + 2);
        expect_ack(1, 1'b1, 8'h00, t0 + 5);
        expect_ack(0, 1'b1, 8'h00, t0 + 8);
        expect_ack(1, 1'b1, 8'h00, t0 + 11);
        fork
            wait_acks(0, 2);
            wait_acks(1, 2);
        join
        last_port = 1'b1;
        @(negedge clock);
        score();
`endif

        foreach (vecs[i]) run_single(vecs[i]);

        // Simultaneous reads: winner acked at 2+LAT, loser granted in the next IDLE cycle.
        drive(0, 1'b0, 16'h0123, 8'h00);
        drive(1, 1'b0, 16'h0456, 8'h00);
        t0 = cyc;
`ifdef MEM_ARB_RR_EN
        first = !last_port;
        last_port = !first;
`else
        first = 1'b0;
`endif
        expect_ack(first, 1'b0, first ? 8'h5A : 8'hA5, t0 + 2 + LAT);
        expect_ack(!first, 1'b0, first ? 8'hA5 : 8'h5A, t0 + 5 + 2 * LAT);
        fork
            wait_acks(0, 1);
            wait_acks(1, 1);
        join
        @(negedge clock);
        score();

`ifndef MEM_ARB_RR_EN
        // Starvation limit: 4 CPU grants, one ext grant, then CPU again.
        drive(0, 1'b1, 16'h0200, 8'h21);
        drive(1, 1'b1, 16'h0300, 8'h31);
        t0 = cyc;
        for (int k = 0; k < MAXB; k++) expect_ack(0, 1'b1, 8'h00, t0 + 2 + 3 * k);
        expect_ack(1, 1'b1, 8'h00, t0 + 2 + 3 * MAXB);
        expect_ack(0, 1'b1, 8'h00, t0 + 5 + 3 * MAXB);
        fork
            wait_acks(0, MAXB + 1);
            wait_acks(1, 1);
        join
        @(negedge clock);
        check("burst_cnt_cleared", u_dut.burst_cnt, 0);
        score();
`endif

        // Reset in the middle of an ext read's WAIT phase: abandoned, no ack.
        drive(1, 1'b0, 16'h0456, 8'h00);
        repeat (3) @(negedge clock);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_owner", owner, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        ext_req = 1'b0;
        exp_crd = '0;
        exp_erd = '0;
`ifdef MEM_ARB_RR_EN
        last_port = 1'b1;
`endif
        @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        score();
        check("post_rst_busy", busy, 0);
        run_single('{1'b0, 1'b0, 16'h0077, 8'h00, 8'h3C});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port data/video memory between the CPU datapath (MRD/MWD/MWV accesses addressed by the register-file address pair) and an external requester (loader or video refresh engine). It sits between the register file's memory-control outputs and the memory macro. It serialises requests, issues one registered memory access at a time, tracks the read latency, and returns a one-cycle acknowledge with read data.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, memory read latency in cycles (legal 1..4)
- MAX_BURST, 4, consecutive CPU grants allowed while ext_req is pending (legal 1..15)

- clock  in  1  single system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting clears all state immediately
- cpu_req / ext_req  in  1  request, held until matching ack
- cpu_we / ext_we  in  1  1 = write, 0 = read; stable while req high
- cpu_addr / ext_addr  in  ADDR_W  access address
- cpu_wdata / ext_wdata  in  DATA_W  write data
- cpu_ack / ext_ack  out  1  one-cycle completion pulse
- cpu_rdata / ext_rdata  out  DATA_W  read data, valid with ack, held until that port's next read ack
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the mem_en cycle
- busy  out  1  high whenever state is not IDLE
- owner  out  1  0 = CPU, 1 = ext; owner of the current or most recent grant

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: when no request is high, stay. Otherwise select a winner, latch its we/addr/wdata into the mem_* registers and go to ISSUE.
- ISSUE: mem_en=1 for exactly one cycle. A write goes to ACK. A read loads the latency counter with RD_LAT and goes to WAIT.
- WAIT: decrement the counter each cycle. At count 1, capture mem_rdata into the owner's rdata register and go to ACK.
- ACK: pulse the owner's ack, return to IDLE. Requests are not sampled during ISSUE, WAIT or ACK.
- Arbitration (default): CPU has fixed priority. A saturating burst counter increments on each CPU grant made while ext_req is high, and clears on any ext grant. When the counter equals MAX_BURST and ext_req is high, ext wins.
- Dropping req before ack is a protocol violation. The transaction still completes and the ack is still issued.
- mem_we, mem_addr and mem_wdata hold their last values outside ISSUE. mem_en alone qualifies an access.
- The rdata of the non-owner port never changes.

## Timing
- Reset values: all outputs 0, state IDLE, burst counter 0, latency counter 0, owner 0, round-robin pointer favouring CPU.
- Take cycle 0 as the first cycle in which req is high with the arbiter in IDLE. Then mem_en is high in cycle 1.
- Write ack is in cycle 2. Read ack is in cycle 2+RD_LAT.
- Back-to-back throughput: 3 cycles per write and 3+RD_LAT cycles per read. The earliest next grant is evaluated in the cycle after ack.
- Both requests high in the same IDLE cycle: the arbitration rule decides. The loser stays pending with no ack.
- Reset asserted mid-transaction: the access is abandoned, no ack is issued, and mem_en drops asynchronously.

## Configuration
- MEM_ARB_RR_EN defined: strict round-robin arbitration.
  - When both requests are pending, the port not granted last wins.
  - A single pending request is granted immediately.
  - The burst counter and MAX_BURST are compiled out.
- MEM_ARB_RR_EN undefined: CPU priority with the MAX_BURST starvation limit, as described above.

## Test plan
- CPU write only (RD_LAT=1): cpu_req, cpu_we=1, addr 16'h0123, wdata 8'hA5 at cycle 0 -> mem_en=1, mem_we=1, mem_addr=16'h0123, mem_wdata=8'hA5 in cycle 1; cpu_ack in cycle 2; ext_ack stays 0.
- CPU read (RD_LAT=3): model returns 8'h3C -> mem_en in cycle 1, cpu_ack with cpu_rdata=8'h3C in cycle 5; busy high in cycles 1-5.
- Simultaneous reads in default mode -> CPU acked first (cycle 3 at RD_LAT=1), ext granted in the next IDLE cycle; each port sees only its own data.
- Starvation (MAX_BURST=4): CPU requests continuously, ext_req held -> exactly 4 CPU grants, then one ext grant, then CPU again; burst counter back to 0.
- Reset pulse during WAIT of a read (RD_LAT=4) -> no ack, all outputs 0; a fresh request after reset release completes normally.
- With MEM_ARB_RR_EN, both ports requesting continuously -> grants strictly alternate CPU, ext, CPU, ext starting with CPU after reset.
